// File: rtl/serv_state_fsm.sv
// Instruction-phase sequencer for a width-configurable SERV datapath: fetch, RF read,
// init stage, stall, write request, second stage and WFI sleep, with a W-bit-per-cycle counter.
module serv_state_fsm #(
  parameter int W          = 1,
  parameter bit WITH_SLEEP = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ibus_ack,
  input  logic       i_two_stage_op,
  input  logic       i_rf_ready,
  input  logic       i_stage_go,
  input  logic       i_wfi,
  input  logic       i_wakeup,
  output logic       o_ibus_cyc,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_ctrl_pc_en,
  output logic       o_sleep
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_RREQ,
    S_INIT,
    S_STALL,
    S_WREQ,
    S_RUN,
    S_SLEEP
  } state_e;

  // W=32 steps by 0 so the single beat of a stage sits at index 0.
  localparam logic [4:0] CNT_STEP = 5'(W % 32);
  localparam logic [4:0] CNT_LAST = 5'(32 - W);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       wreq_first_q, wreq_first_d;
  logic       counting;
  logic       cnt_last;

  assign counting = (state_q == S_INIT) || (state_q == S_RUN);
  assign cnt_last = counting && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      wreq_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wreq_first_q <= wreq_first_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = counting ? (cnt_q + CNT_STEP) : '0;
    unique case (state_q)
      S_FETCH: if (i_ibus_ack) state_d = S_RREQ;
      S_RREQ:  if (i_rf_ready) state_d = i_two_stage_op ? S_INIT : S_RUN;
      S_INIT: begin
        if (cnt_last) begin
          if (WITH_SLEEP && i_wfi) state_d = S_SLEEP;
          else if (i_stage_go)     state_d = S_WREQ;
          else                     state_d = S_STALL;
        end
      end
      S_STALL: if (i_stage_go) state_d = S_WREQ;
      S_WREQ:  if (i_rf_ready) state_d = S_RUN;
      S_RUN:   if (cnt_last)   state_d = S_FETCH;
      S_SLEEP: if (i_wakeup)   state_d = S_WREQ;
      default: state_d = S_FETCH;
    endcase
    wreq_first_d = (state_d == S_WREQ) && (state_q != S_WREQ);
  end

  // Reset parks the FSM in FETCH, so the fetch request is masked by rst_n to keep outputs low.
  always_comb begin
    o_ibus_cyc    = i_rst_n && (state_q == S_FETCH);
    o_rf_rreq     = o_ibus_cyc && i_ibus_ack;
    o_rf_wreq     = (state_q == S_WREQ) && wreq_first_q;
    o_init        = (state_q == S_INIT);
    o_cnt_en      = counting;
    o_cnt         = cnt_q;
    o_cnt_done    = cnt_last;
    o_cnt0to3     = counting && (cnt_q < 5'd4);
    o_cnt12to31   = counting && (cnt_q >= 5'd12);
    o_mem_bytecnt = cnt_q[4:3];
    o_ctrl_pc_en  = (state_q == S_RUN);
    o_sleep       = (state_q == S_SLEEP);
  end

endmodule

// File: doc/serv_state_fsm.md
Name: serv_state_fsm

Overview:
- Parametrised successor to the SERV core state/counter block.
- Replaces the fixed 1/4-bit shift-register counter with an explicit instruction-phase FSM and a bit-position counter that advances W bits per cycle, for W in {1,2,4,8,16,32}.
- Sequences fetch, RF read, init stage, stall, second stage and WFI sleep.
- Sits between the decoder, bus interfaces and register-file interface of a width-configurable SERV datapath.

Parameters:
- W, 1: datapath bits per cycle; legal values 1,2,4,8,16,32. Beats per stage = 32/W.
- WITH_SLEEP, 1: 1 enables the SLEEP state; 0 makes i_wfi ignored.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ibus_ack  in  1  instruction fetch acknowledge.
- i_two_stage_op  in  1  decoded instruction needs an init stage.
- i_rf_ready  in  1  RF ready; starts a counting stage.
- i_stage_go  in  1  stall condition resolved (dbus ack / shift done / MDU ready).
- i_wfi  in  1  current instruction is WFI.
- i_wakeup  in  1  enabled interrupt pending.
- o_ibus_cyc  out  1  fetch request.
- o_rf_rreq  out  1  one-cycle RF read request.
- o_rf_wreq  out  1  one-cycle RF write request for the second stage.
- o_init  out  1  currently in the init stage.
- o_cnt_en  out  1  counter running.
- o_cnt  out  5  current bit index; low log2(W) bits always 0.
- o_cnt_done  out  1  last beat of the current stage.
- o_cnt0to3  out  1  o_cnt_en & o_cnt<4.
- o_cnt12to31  out  1  o_cnt_en & o_cnt>=12.
- o_mem_bytecnt  out  2  o_cnt[4:3].
- o_ctrl_pc_en  out  1  o_cnt_en & !o_init.
- o_sleep  out  1  in SLEEP state.

Behaviour:
- States: FETCH, RREQ, INIT, STALL, WREQ, RUN, SLEEP.
- Reset (i_rst_n=0, asynchronous):
  - state=FETCH, o_cnt=0.
  - All outputs 0 while reset is held, including o_ibus_cyc, which is gated by i_rst_n.
  - o_ibus_cyc=1 in the first cycle after release.
  - Reset asserted mid-stage aborts immediately; no done pulse is produced.
- FETCH:
  - o_ibus_cyc=1.
  - On i_ibus_ack: o_rf_rreq=1 in that same cycle (combinational), next state RREQ.
- RREQ: on i_rf_ready, go to INIT if i_two_stage_op, else RUN. Counter starts at 0 in the following cycle.
- INIT / RUN (counting):
  - o_cnt_en=1; o_cnt += W each cycle.
  - o_cnt_done=1 when o_cnt==32-W; o_cnt wraps to 0 on the next edge.
  - W=32: a stage is exactly one cycle, o_cnt=0 and o_cnt_done=1.
  - o_init=1 only in INIT.
- INIT exit on o_cnt_done:
  - if i_wfi & WITH_SLEEP: go to SLEEP;
  - else if i_stage_go is sampled high on that same done cycle: go to WREQ;
  - else: go to STALL.
- STALL: on i_stage_go, go to WREQ.
- WREQ:
  - o_rf_wreq=1 for exactly the first cycle in WREQ.
  - Wait for i_rf_ready, then go to RUN.
  - i_rf_ready already high in the first WREQ cycle: RUN starts next cycle.
- RUN exit on o_cnt_done: go to FETCH; o_ibus_cyc rises the next cycle.
- SLEEP:
  - o_sleep=1, counter idle.
  - On i_wakeup: go to WREQ.
  - i_wakeup already high on the INIT done cycle: still enter SLEEP for exactly one cycle.
- Ignored inputs: i_ibus_ack outside FETCH; i_rf_ready outside RREQ/WREQ; i_stage_go outside INIT-done/STALL.
- Count length: o_cnt never exceeds 32-W. Exactly 32/W beats per stage.

Test Plan:
- W=1, single-stage op:
  - Stimulus: ibus_ack at t0, rf_ready at t2.
  - Required: rf_rreq at t0; RUN for 32 cycles; cnt_done with o_cnt=31; ibus_cyc=1 one cycle after done; o_ctrl_pc_en high for all 32 beats.
- W=4, two-stage op:
  - Stimulus: stage_go 3 cycles after init done.
  - Required: INIT 8 beats (o_cnt 0,4,...,28); STALL 3 cycles; rf_wreq single pulse; RUN 8 beats; o_mem_bytecnt steps 0,0,1,1,2,2,3,3.
- W=32:
  - Stimulus: two-stage op with stage_go already high.
  - Required: INIT 1 cycle with cnt_done=1 and o_cnt=0; then WREQ; RUN 1 cycle.
- WFI:
  - Stimulus: i_wfi=1 with WITH_SLEEP=1; i_wakeup raised 10 cycles after init done.
  - Required: o_sleep for 10 cycles, then rf_wreq and RUN.
  - Same stimulus with WITH_SLEEP=0: goes to STALL, never SLEEP.
- Reset:
  - Stimulus: i_rst_n=0 asynchronously at INIT beat 5 (W=1).
  - Required: o_cnt=0 and o_cnt_en=0 with no clock edge; o_ibus_cyc=1 in the first cycle after release.
- Sweep:
  - Stimulus: random stall and ack delays for every legal W.
  - Required: exactly 32/W beats per stage; rf_rreq count equals fetch count; low log2(W) bits of o_cnt always 0.
